// File: rtl/encoder83_pending_pkg.sv
// Shared types and sizes for the 8-to-3 pending request encoder.
// The helper turns an encoded index back into the pending-bit mask it refers to.
package encoder83_pending_pkg;

    localparam int IDX_W = 3;
    localparam int REQ_W = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    function automatic logic [REQ_W-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        idx_onehot      = '0;
        idx_onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/encoder83_pending_if.sv
// Request/handshake bundle between the request sources, the encoder and the index consumer.
// code[0] is the LSB of the encoded index; req_n[i] belongs to source i.
interface encoder83_pending_if;
    import encoder83_pending_pkg::*;

    logic [0:REQ_W-1] req_n;
    logic             en_n;
    logic [0:IDX_W-1] code;
    logic             valid;
    logic             ready;
    logic             gs_n;
    logic             eo_n;

    modport master (
        input  req_n, en_n, ready,
        output code, valid, gs_n, eo_n
    );

    modport slave (
        output req_n, en_n, ready,
        input  code, valid, gs_n, eo_n
    );

endinterface

// File: rtl/encoder83_pending_prio_find8.sv
// Combinational find-first-set over 8 bits; PRIO_HIGH=1 favours the highest index,
// PRIO_HIGH=0 the lowest.
module prio_find8
    import encoder83_pending_pkg::*;
#(
    parameter bit PRIO_HIGH = 1'b1
) (
    input  logic [REQ_W-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Later loop iterations overwrite earlier ones, so the scan order sets the winner.
    always_comb begin
        idx = '0;
        any = |vec;
        if (PRIO_HIGH) begin
            for (int i = 0; i < REQ_W; i++) begin
                if (vec[i]) idx = IDX_W'(i);
            end
        end else begin
            for (int i = REQ_W - 1; i >= 0; i--) begin
                if (vec[i]) idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/encoder83_pending.sv
// Registered 8-to-3 priority encoder: latches active-low requests into a pending
// register and offers one index at a time over a valid/ready handshake.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | nothing offered; load the best pending index if any
//   ST_OFFER | code/valid held until the consumer asserts ready
module encoder83_pending
    import encoder83_pending_pkg::*;
#(
    parameter bit PRIO_HIGH = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    encoder83_pending_if.master bus
);

    state_t           state_q, state_d;
    logic [REQ_W-1:0] p_q, p_d;
    logic [IDX_W-1:0] code_q, code_d;
    logic             valid_q, valid_d;
    logic             gs_n_q, gs_n_d;
    logic             eo_n_q, eo_n_d;

    logic [REQ_W-1:0] set_mask;
    logic [REQ_W-1:0] clr_mask;
    logic [IDX_W-1:0] find_idx;
    logic             find_any;

    prio_find8 #(
        .PRIO_HIGH (PRIO_HIGH)
    ) u_find (
        .vec (p_q),
        .idx (find_idx),
        .any (find_any)
    );

    always_comb begin
        set_mask = '0;
        for (int i = 0; i < REQ_W; i++) begin
            set_mask[i] = ~bus.en_n & ~bus.req_n[i];
        end
    end

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        valid_d  = valid_q;
        clr_mask = '0;
        case (state_q)
            ST_IDLE: begin
                if (find_any) begin
                    code_d  = find_idx;
                    valid_d = 1'b1;
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (bus.ready) begin
                    clr_mask = idx_onehot(code_q);
                    valid_d  = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // A request arriving on the accept edge re-arms its own bit: set beats clear.
    always_comb begin
        p_d    = (p_q & ~clr_mask) | set_mask;
        gs_n_d = ~(|p_d);
        eo_n_d = ~(~bus.en_n & ~(|p_d) & (&bus.req_n));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            p_q     <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            gs_n_q  <= 1'b1;
            eo_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            gs_n_q  <= gs_n_d;
            eo_n_q  <= eo_n_d;
        end
    end

    assign bus.code[0] = code_q[0];
    assign bus.code[1] = code_q[1];
    assign bus.code[2] = code_q[2];
    assign bus.valid   = valid_q;
    assign bus.gs_n    = gs_n_q;
    assign bus.eo_n    = eo_n_q;

endmodule

// File: tb/tb_encoder83_pending.sv
// Bench for encoder83_pending: both priority orders driven side by side, checked
// every cycle against a set-of-pending-indices model plus directed offer sequences.
module tb_encoder83_pending;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:7] req_n;
    logic       en_n;
    logic       ready;

    always #5 clk = ~clk;

    encoder83_pending_if if_h ();
    encoder83_pending_if if_l ();

    assign if_h.req_n = req_n;
    assign if_h.en_n  = en_n;
    assign if_h.ready = ready;
    assign if_l.req_n = req_n;
    assign if_l.en_n  = en_n;
    assign if_l.ready = ready;

    encoder83_pending #(.PRIO_HIGH(1'b1)) dut_h (.clk(clk), .rst(rst), .bus(if_h.master));
    encoder83_pending #(.PRIO_HIGH(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(if_l.master));

    int checks   = 0;
    int failures = 0;

    // Model: per DUT (0 = high-first, 1 = low-first) the set of pending indices,
    // the index currently on offer (-1 = none) and the last code shown.
    bit pend   [2][8];
    int offer  [2];
    int code_m [2];
    bit gs_m   [2];
    bit eo_m   [2];
    int acc    [2][$];
    int expq   [$];

    function automatic logic [7:0] code_h();
        return {5'b0, if_h.code[2], if_h.code[1], if_h.code[0]};
    endfunction

    function automatic logic [7:0] code_l();
        return {5'b0, if_l.code[2], if_l.code[1], if_l.code[0]};
    endfunction

    function automatic int best(int m);
        if (m == 0) begin
            for (int i = 7; i >= 0; i--) if (pend[m][i]) return i;
        end else begin
            for (int i = 0; i < 8; i++) if (pend[m][i]) return i;
        end
        return -1;
    endfunction

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int  b;
        bit  any;
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                for (int i = 0; i < 8; i++) pend[m][i] = 1'b0;
                offer[m]  = -1;
                code_m[m] = 0;
                gs_m[m]   = 1'b1;
                eo_m[m]   = 1'b1;
            end else begin
                if (offer[m] < 0) begin
                    b = best(m);
                    if (b >= 0) begin
                        offer[m]  = b;
                        code_m[m] = b;
                    end
                end else if (ready) begin
                    pend[m][offer[m]] = 1'b0;
                    offer[m] = -1;
                end
                for (int i = 0; i < 8; i++) begin
                    if (!en_n && !req_n[i]) pend[m][i] = 1'b1;
                end
                any = 1'b0;
                for (int i = 0; i < 8; i++) any |= pend[m][i];
                gs_m[m] = !any;
                eo_m[m] = !(!en_n && !any && (req_n == 8'hFF));
            end
        end
    endtask

    task automatic check_all();
        chk("h.valid", 8'(if_h.valid), 8'(offer[0] >= 0));
        chk("h.code",  code_h(),       8'(code_m[0]));
        chk("h.gs_n",  8'(if_h.gs_n),  8'(gs_m[0]));
        chk("h.eo_n",  8'(if_h.eo_n),  8'(eo_m[0]));
        chk("l.valid", 8'(if_l.valid), 8'(offer[1] >= 0));
        chk("l.code",  code_l(),       8'(code_m[1]));
        chk("l.gs_n",  8'(if_l.gs_n),  8'(gs_m[1]));
        chk("l.eo_n",  8'(if_l.eo_n),  8'(eo_m[1]));
    endtask

    // Inputs are stable here (set after the previous edge); log accepts, clock, compare.
    task automatic cycle();
        if (!rst && if_h.valid === 1'b1 && ready) acc[0].push_back(int'(code_h()));
        if (!rst && if_l.valid === 1'b1 && ready) acc[1].push_back(int'(code_l()));
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic chk_seq(string tag, int m, int exp[$]);
        chk($sformatf("%s.len", tag), 8'(acc[m].size()), 8'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            chk($sformatf("%s[%0d]", tag, i),
                8'((i < acc[m].size()) ? acc[m][i] : -1), 8'(exp[i]));
        end
    endtask

    task automatic clear_acc();
        acc[0].delete();
        acc[1].delete();
    endtask

    initial begin
        offer  = '{-1, -1};
        code_m = '{0, 0};
        rst = 1'b1; req_n = 8'hFF; en_n = 1'b0; ready = 1'b0;
        repeat (2) cycle();
        chk("rst.valid", 8'(if_h.valid), 8'd0);
        chk("rst.eo_n",  8'(if_h.eo_n),  8'd1);

        rst = 1'b0;
        cycle();
        chk("idle.eo_n", 8'(if_h.eo_n), 8'd0);
        chk("idle.gs_n", 8'(if_h.gs_n), 8'd1);

        // single request, two-edge latency
        req_n[5] = 1'b0; ready = 1'b1;
        cycle();
        chk("r5.gs_n", 8'(if_h.gs_n), 8'd0);
        req_n = 8'hFF;
        cycle();
        chk("r5.valid", 8'(if_h.valid), 8'd1);
        chk("r5.code",  code_h(),       8'd5);
        cycle();
        chk("r5.drop", 8'(if_h.valid), 8'd0);
        chk("r5.gs_hi", 8'(if_h.gs_n), 8'd1);

        // two simultaneous requests, order depends on PRIO_HIGH
        clear_acc();
        req_n[2] = 1'b0; req_n[6] = 1'b0;
        cycle();
        req_n = 8'hFF;
        repeat (6) cycle();
        expq = '{6, 2}; chk_seq("hi.26", 0, expq);
        expq = '{2, 6}; chk_seq("lo.26", 1, expq);

        // backpressure: offer of 3 is not re-evaluated when 7 arrives
        clear_acc();
        ready = 1'b0;
        req_n[3] = 1'b0;
        cycle();
        req_n = 8'hFF;
        cycle();
        repeat (10) cycle();
        req_n[7] = 1'b0;
        cycle();
        req_n = 8'hFF;
        cycle();
        chk("bp.h.code",  code_h(),       8'd3);
        chk("bp.h.valid", 8'(if_h.valid), 8'd1);
        chk("bp.l.code",  code_l(),       8'd3);
        ready = 1'b1;
        repeat (5) cycle();
        expq = '{3, 7}; chk_seq("bp.h", 0, expq);
        expq = '{3, 7}; chk_seq("bp.l", 1, expq);

        // held request re-offered every two cycles
        clear_acc();
        req_n[4] = 1'b0;
        repeat (9) cycle();
        expq = '{4, 4, 4, 4}; chk_seq("hold.h", 0, expq);
        expq = '{4, 4, 4, 4}; chk_seq("hold.l", 1, expq);
        req_n = 8'hFF;
        repeat (4) cycle();

        // capture disabled
        en_n = 1'b1; req_n = 8'h00;
        repeat (4) cycle();
        chk("en.valid", 8'(if_h.valid), 8'd0);
        chk("en.gs_n",  8'(if_l.gs_n),  8'd1);
        en_n = 1'b0; req_n = 8'hFF;
        cycle();

        // all eight pending, drained in priority order
        clear_acc();
        req_n = 8'h00;
        cycle();
        req_n = 8'hFF;
        repeat (18) cycle();
        expq = '{7, 6, 5, 4, 3, 2, 1, 0}; chk_seq("all.h", 0, expq);
        expq = '{0, 1, 2, 3, 4, 5, 6, 7}; chk_seq("all.l", 1, expq);
        chk("all.gs_n", 8'(if_h.gs_n), 8'd1);

        // reset while offering drops everything
        ready = 1'b0;
        req_n[1] = 1'b0; req_n[6] = 1'b0;
        cycle();
        req_n = 8'hFF;
        cycle();
        chk("mid.valid_pre", 8'(if_h.valid), 8'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mid.valid", 8'(if_h.valid), 8'd0);
        cycle();
        chk("mid.gs_n", 8'(if_h.gs_n), 8'd1);
        clear_acc();
        ready = 1'b1;
        repeat (4) cycle();
        chk("mid.none.h", 8'(acc[0].size()), 8'd0);
        chk("mid.none.l", 8'(acc[1].size()), 8'd0);

        // randomized traffic
        repeat (400) begin
            rst   = ($urandom_range(0, 63) == 0);
            en_n  = ($urandom_range(0, 3) == 0);
            ready = 1'($urandom_range(0, 1));
            for (int i = 0; i < 8; i++) req_n[i] = ($urandom_range(0, 7) != 0);
            cycle();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
